// File: rtl/arb2_pkg.sv
// -----------------------------------------------------------------------------
// arb2_pkg
// Shared constants and types for the two-input round-robin stream selector.
//   SRC_I0 / SRC_I1 : encodings of the two sources, also the value carried on p0
//   ARB2_W_DEF      : default payload width
//   arb2_beat_t     : {data, sel[, last]} output beat at the default width
//   other_src()     : the source that is not the given one (priority rotation)
// Optional feature macro: ARB2_PKT_LOCK_EN adds the 'last' field to the beat.
// -----------------------------------------------------------------------------
package arb2_pkg;

  localparam logic SRC_I0 = 1'b0;
  localparam logic SRC_I1 = 1'b1;

  localparam int ARB2_W_DEF = 8;

  typedef struct packed {
    logic [ARB2_W_DEF-1:0] data;
    logic                  sel;
`ifdef ARB2_PKT_LOCK_EN
    logic                  last;
`endif
  } arb2_beat_t;

  function automatic logic other_src(input logic src);
    return ~src;
  endfunction

endpackage

// File: rtl/arb2_rr_pick.sv
// -----------------------------------------------------------------------------
// arb2_rr_pick
// Combinational winner selection for the two-input round-robin arbiter.
//   i_v0, i_v1     : source valids
//   i_prio         : source that wins when both are eligible
//   i_lock         : a packet is in progress; only i_lock_src may win
//   i_lock_src     : source owning the packet lock
//   o_winner       : selected source (meaningful only with o_grant_valid)
//   o_grant_valid  : at least one eligible source is requesting
// Depends only on valids and arbitration state, never on payload.
// -----------------------------------------------------------------------------
module arb2_rr_pick
  import arb2_pkg::*;
(
  input  logic i_v0,
  input  logic i_v1,
  input  logic i_prio,
  input  logic i_lock,
  input  logic i_lock_src,
  output logic o_winner,
  output logic o_grant_valid
);

  logic w_elig0;
  logic w_elig1;

  // A locked packet masks the non-owning source even when priority favours it.
  assign w_elig0 = i_v0 && !(i_lock && (i_lock_src == SRC_I1));
  assign w_elig1 = i_v1 && !(i_lock && (i_lock_src == SRC_I0));

  assign o_grant_valid = w_elig0 || w_elig1;

  // NOTE: every output of a combinational block is assigned on all paths here,
  // so no latch can be inferred.
  always_comb begin
    o_winner = SRC_I0;
    if (w_elig0 && w_elig1) begin
      o_winner = i_prio;
    end else if (w_elig1) begin
      o_winner = SRC_I1;
    end
  end

endmodule

// File: rtl/arb2_stream_sel.sv
// -----------------------------------------------------------------------------
// arb2_stream_sel
// Registered two-input round-robin arbiter feeding a 2:1 select stage. One beat
// per cycle is accepted from i0 or i1 and presented on a single registered
// output together with p0, the source select downstream muxes steer on.
//   clk, rst_n             : clock, asynchronous active-low reset
//   i0_valid/ready/data    : source 0 stream
//   i1_valid/ready/data    : source 1 stream
//   out_valid/ready/data   : registered winning beat
//   p0                     : registered select, 0 = from i0, 1 = from i1
//   i0_last, i1_last,
//   out_last               : packet delimiters (only with ARB2_PKT_LOCK_EN)
// Optional feature macro: ARB2_PKT_LOCK_EN -- packet lock: once a source wins
// a beat with last=0 it keeps the output until it sends a beat with last=1.
// -----------------------------------------------------------------------------
module arb2_stream_sel
  import arb2_pkg::*;
#(
  parameter int   W         = ARB2_W_DEF,
  parameter logic PRIO_INIT = SRC_I0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i0_valid,
  output logic         i0_ready,
  input  logic [W-1:0] i0_data,
  input  logic         i1_valid,
  output logic         i1_ready,
  input  logic [W-1:0] i1_data,
`ifdef ARB2_PKT_LOCK_EN
  input  logic         i0_last,
  input  logic         i1_last,
  output logic         out_last,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         p0
);

  // Beat layout at this instance's width; mirrors arb2_beat_t.
  typedef struct packed {
    logic [W-1:0] data;
    logic         sel;
`ifdef ARB2_PKT_LOCK_EN
    logic         last;
`endif
  } beat_t;

  beat_t r_beat;
  logic  r_out_valid;
  logic  r_prio;
  logic  r_lock;
  logic  r_lock_src;

  beat_t w_next;
  logic  w_load;
  logic  w_winner;
  logic  w_grant_valid;
  logic  w_accept;

  // Output slot can take a new beat when empty or draining this cycle.
  assign w_load   = !r_out_valid || out_ready;
  assign w_accept = w_load && w_grant_valid;

  arb2_rr_pick u_pick (
    .i_v0          (i0_valid),
    .i_v1          (i1_valid),
    .i_prio        (r_prio),
    .i_lock        (r_lock),
    .i_lock_src    (r_lock_src),
    .o_winner      (w_winner),
    .o_grant_valid (w_grant_valid)
  );

  // Readies are forced low during reset even though the slot looks free.
  assign i0_ready = rst_n && w_accept && (w_winner == SRC_I0);
  assign i1_ready = rst_n && w_accept && (w_winner == SRC_I1);

  always_comb begin
    w_next      = '0;
    w_next.sel  = w_winner;
    w_next.data = (w_winner == SRC_I1) ? i1_data : i0_data;
`ifdef ARB2_PKT_LOCK_EN
    w_next.last = (w_winner == SRC_I1) ? i1_last : i0_last;
`endif
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat      <= '0;
      r_out_valid <= 1'b0;
      r_prio      <= PRIO_INIT;
    end else if (w_load) begin
      if (w_grant_valid) begin
        r_beat      <= w_next;
        r_out_valid <= 1'b1;
        r_prio      <= other_src(w_winner);
      end else begin
        // Payload and select hold; only the valid flag drops.
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef ARB2_PKT_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock     <= 1'b0;
      r_lock_src <= SRC_I0;
    end else if (w_accept) begin
      r_lock     <= !w_next.last;
      r_lock_src <= w_winner;
    end
  end

  assign out_last = r_beat.last;
`else
  assign r_lock     = 1'b0;
  assign r_lock_src = SRC_I0;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_beat.data;
  assign p0        = r_beat.sel;

endmodule

// File: tb/tb_arb2_stream_sel.sv
// -----------------------------------------------------------------------------
// tb_arb2_stream_sel
// Directed and randomized stimulus for arb2_stream_sel, checked against a
// transaction-level reference model of the arbitration rules.
// Optional feature macro: ARB2_PKT_LOCK_EN (adds the packet-lock scenario).
// -----------------------------------------------------------------------------
module tb_arb2_stream_sel;
  import arb2_pkg::*;

  localparam int   W         = ARB2_W_DEF;
  localparam logic PRIO_INIT = SRC_I0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i0_valid, i1_valid;
  logic         i0_ready, i1_ready;
  logic [W-1:0] i0_data, i1_data;
  logic         out_valid, out_ready;
  logic [W-1:0] out_data;
  logic         p0;
`ifdef ARB2_PKT_LOCK_EN
  logic         i0_last = 1'b1;
  logic         i1_last = 1'b1;
  logic         out_last;
`endif

  always #5 clk = ~clk;

  arb2_stream_sel #(.W(W), .PRIO_INIT(PRIO_INIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i0_valid  (i0_valid),
    .i0_ready  (i0_ready),
    .i0_data   (i0_data),
    .i1_valid  (i1_valid),
    .i1_ready  (i1_ready),
    .i1_data   (i1_data),
`ifdef ARB2_PKT_LOCK_EN
    .i0_last   (i0_last),
    .i1_last   (i1_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .p0        (p0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents of the output slot plus arbitration state.
  arb2_beat_t m_beat;
  logic       m_valid;
  logic       m_prio;
  logic       m_lock;
  logic       m_lock_src;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid    = 1'b0;
    m_beat     = '0;
    m_prio     = PRIO_INIT;
    m_lock     = 1'b0;
    m_lock_src = SRC_I0;
  endtask

  // One cycle: drive inputs just after a falling edge, check readies before the
  // rising edge, advance the model, check registers 1 time unit after the edge.
  task automatic step(input logic v0, input logic v1, input logic [W-1:0] d0,
                      input logic [W-1:0] d1, input logic ordy);
    logic e0, e1, has, win, free, lst;
    i0_valid  = v0;
    i1_valid  = v1;
    i0_data   = d0;
    i1_data   = d1;
    out_ready = ordy;
    #1;
    e0   = v0 && !(m_lock && m_lock_src == SRC_I1);
    e1   = v1 && !(m_lock && m_lock_src == SRC_I0);
    has  = e0 || e1;
    win  = (e0 && e1) ? m_prio : e1;
    free = !m_valid || ordy;
    lst  = 1'b1;
`ifdef ARB2_PKT_LOCK_EN
    lst  = win ? i1_last : i0_last;
`endif
    check("i0_ready", {31'd0, i0_ready}, {31'd0, free && has && !win});
    check("i1_ready", {31'd0, i1_ready}, {31'd0, free && has && win});
    @(posedge clk);
    #1;
    if (free) begin
      if (has) begin
        m_valid     = 1'b1;
        m_beat.data = win ? d1 : d0;
        m_beat.sel  = win;
        m_prio      = !win;
        m_lock      = !lst;
        m_lock_src  = win;
`ifdef ARB2_PKT_LOCK_EN
        m_beat.last = lst;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("out_data", {24'd0, out_data}, {24'd0, m_beat.data});
    check("p0", {31'd0, p0}, {31'd0, m_beat.sel});
`ifdef ARB2_PKT_LOCK_EN
    check("out_last", {31'd0, out_last}, {31'd0, m_beat.last});
`endif
    @(negedge clk);
  endtask

  initial begin
    // Reset held with both sources requesting.
    rst_n     = 1'b0;
    i0_valid  = 1'b1;
    i1_valid  = 1'b1;
    i0_data   = 8'hA0;
    i1_data   = 8'hB1;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_p0", {31'd0, p0}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_i0_ready", {31'd0, i0_ready}, 32'd0);
    check("rst_i1_ready", {31'd0, i1_ready}, 32'd0);
    rst_n = 1'b1;

    // Alternation from PRIO_INIT: A0, B1, A0, B1.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 8'hA0, 8'hB1, 1'b1);
      check("alt_data", {24'd0, out_data}, (k % 2) ? 32'hB1 : 32'hA0);
      check("alt_p0", {31'd0, p0}, (k % 2) ? 32'd1 : 32'd0);
    end

    // Single source i1.
    step(1'b0, 1'b1, 8'h00, 8'h3C, 1'b1);
    check("single_3c", {24'd0, out_data}, 32'h3C);
    step(1'b0, 1'b1, 8'h00, 8'h3D, 1'b1);
    check("single_3d", {24'd0, out_data}, 32'h3D);
    check("single_p0", {31'd0, p0}, 32'd1);

    // Backpressure: 55 held for 3 stalled cycles, then i1 (priority) loads.
    step(1'b1, 1'b0, 8'h55, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 8'h66, 8'h77, 1'b0);
      check("stall_data", {24'd0, out_data}, 32'h55);
      check("stall_p0", {31'd0, p0}, 32'd0);
    end
    step(1'b1, 1'b1, 8'h66, 8'h77, 1'b1);
    check("unstall_data", {24'd0, out_data}, 32'h77);

    // Leave prio pointing at i1, then reset asynchronously mid-cycle.
    step(1'b1, 1'b0, 8'h5A, 8'h00, 1'b1);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_p0", {31'd0, p0}, 32'd0);
    check("arst_i0_ready", {31'd0, i0_ready}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 8'hA0, 8'hB1, 1'b1);
    check("arst_prio_data", {24'd0, out_data}, 32'hA0);

`ifdef ARB2_PKT_LOCK_EN
    // Packet lock: i0 sends a 3-beat packet while i1 is always valid.
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    i0_last = 1'b0;
    step(1'b1, 1'b1, 8'hC0, 8'hD0, 1'b1);
    check("lock_b1_p0", {31'd0, p0}, 32'd0);
    step(1'b1, 1'b1, 8'hC1, 8'hD0, 1'b1);
    check("lock_b2_p0", {31'd0, p0}, 32'd0);
    i0_last = 1'b1;
    step(1'b1, 1'b1, 8'hC2, 8'hD0, 1'b1);
    check("lock_b3_p0", {31'd0, p0}, 32'd0);
    step(1'b1, 1'b1, 8'hC3, 8'hD0, 1'b1);
    check("lock_after_p0", {31'd0, p0}, 32'd1);
    check("lock_after_data", {24'd0, out_data}, 32'hD0);
`endif

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
`ifdef ARB2_PKT_LOCK_EN
      i0_last = ($urandom_range(0, 2) == 0);
      i1_last = ($urandom_range(0, 2) == 0);
`endif
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arb2_stream_sel.md
Name: arb2_stream_sel

Overview:
- Registered two-input round-robin arbiter that sits directly upstream of the 2-to-1 select stage.
- Accepts two valid/ready data streams (i0, i1) and picks one beat per cycle.
- Presents the winning beat on a single registered output, together with the select bit p0 that identifies the source.
- Downstream consumers use p0 to steer their own 2:1 datapath muxes in lockstep with the data.

Parameters:
- W, 8, data width of each input stream and of the output.
- PRIO_INIT, 0, source that holds priority after reset (0 = i0, 1 = i1).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i0_valid  input  1  source 0 has a beat.
- i0_ready  output  1  source 0 beat accepted this cycle when high with i0_valid.
- i0_data  input  W  source 0 payload.
- i1_valid  input  1  source 1 has a beat.
- i1_ready  output  1  source 1 beat accepted this cycle when high with i1_valid.
- i1_data  input  W  source 1 payload.
- out_valid  output  1  registered output holds a beat.
- out_ready  input  1  downstream accepts the output beat.
- out_data  output  W  registered winning payload.
- p0  output  1  registered select: 0 = out_data came from i0, 1 = from i1.

Behaviour:
- Reset is asynchronous and active-low; reset values:
  - out_valid=0, out_data=0, p0=0.
  - prio=PRIO_INIT.
  - i0_ready=0 and i1_ready=0 while rst_n low.
- Slot free: `load = !out_valid || out_ready`.
- Winner selection (combinational):
  - Both valid: winner = prio.
  - Only i0 valid: winner = 0.
  - Only i1 valid: winner = 1.
  - Neither valid: no winner.
- Readies:
  - `i0_ready = load && winner==0 && i0_valid`.
  - `i1_ready` is symmetric.
  - At most one ready is high per cycle.
  - Readies never depend combinationally on the requester's own data.
- On a clock edge with load and a winner:
  - out_data <= winner data; p0 <= winner; out_valid <= 1.
  - prio <= ~winner.
- On a clock edge with load and no winner: out_valid <= 0; out_data and p0 hold.
- Otherwise (out_valid && !out_ready): all output registers hold stable. Data must not change while stalled.
- Latency: one cycle from input handshake to out_valid.
- Throughput: one beat per cycle with out_ready held high.
- Fairness: with both sources continuously valid, grants alternate 0,1,0,1,… from PRIO_INIT; there is no starvation.
- prio updates only on an accepted input beat. Idle cycles and stall cycles leave it unchanged.
- Simultaneous output drain and input accept in the same cycle is legal and produces a back-to-back beat.
- Reset asserted mid-transfer discards the held beat and returns all registers to reset values; no partial state survives.

Optional Feature:
- Macro ARB2_PKT_LOCK_EN.
- Defined:
  - Adds inputs i0_last and i1_last and output out_last (each 1 bit, registered with data).
  - Adds a lock register (reset 0) and lock_src.
  - After a winning beat with last=0: lock=1 and lock_src=winner.
  - While locked, only lock_src may win; the other source gets ready=0 even if prio favours it.
  - A beat accepted with last=1 clears lock; prio advances as usual.
- Undefined: these ports and registers do not exist, and every beat is arbitrated independently.

Decomposition:
- Shared package arb2_pkg holds:
  - `SRC_I0 = 1'b0` and `SRC_I1 = 1'b1`.
  - The default data width constant.
  - A typedef for the {data, sel[, last]} output beat.
- One natural sub-module, arb2_rr_pick: combinational winner and ready logic (valids, prio, lock in; winner and grant_valid out).
- Output registers and prio/lock state stay in the top level.

Test Plan:
- Reset: hold rst_n=0 with i0_valid=1 and i1_valid=1 -> out_valid=0, p0=0, both readies 0. Release rst_n -> next edge out_data=i0_data and p0=0 (PRIO_INIT=0).
- Alternation: both valid every cycle with i0_data=8'hA0 and i1_data=8'hB1, out_ready=1 -> output sequence A0/p0=0, B1/p0=1, A0, B1 over 4 cycles.
- Single source: only i1_valid with data 8'h3C, 8'h3D -> outputs 3C then 3D with p0=1. i0_ready stays 0.
- Backpressure: out_valid=1 holding 8'h55 and out_ready=0 for 3 cycles -> out_data=55 and p0 stable, both readies 0, prio unchanged. On out_ready=1 the next beat loads the same cycle.
- Async reset mid-stream: drop rst_n between clock edges while out_valid=1 -> out_valid=0 immediately without a clock edge, prio=PRIO_INIT.
- With ARB2_PKT_LOCK_EN defined: i0 sends a 3-beat packet (last on beat 3) while i1 is valid throughout -> three i0 beats with p0=0, then i1 wins.
